// File: rtl/tb_status_periph.sv
// Bench-side status peripheral: end-of-test pass/fail/exit handshake, a small
// stdout byte FIFO and a free-running cycle counter on a req/gnt/rvalid data bus.
module tb_status_periph #(
    parameter logic [31:0] BASE_ADDR        = 32'h2000_0000,
    parameter int unsigned PRINT_FIFO_DEPTH = 4,
    parameter logic [31:0] PASS_CODE        = 32'd123456789,
    parameter logic [31:0] FAIL_CODE        = 32'd1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o,
    output logic        print_valid_o,
    output logic [7:0]  print_data_o,
    input  logic        print_ready_i
);
    localparam int PW = (PRINT_FIFO_DEPTH > 1) ? $clog2(PRINT_FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [2:0] OFF_PRINT  = 3'd0;
    localparam logic [2:0] OFF_TEST   = 3'd1;
    localparam logic [2:0] OFF_EXIT   = 3'd2;
    localparam logic [2:0] OFF_CYCLE  = 3'd3;
    localparam logic [2:0] OFF_STATUS = 3'd4;

    logic          hit;
    logic [2:0]    offset;
    logic          full_word;
    logic          print_wr, push, pop, test_wr, exit_wr, full;
    logic [31:0]   rd_val;
    logic [31:0]   cycle;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [3:0]    count4;
    logic [7:0]    mem [PRINT_FIFO_DEPTH];
    logic          unused_addr;

    // Byte lane within the word is irrelevant: every register is word-wide.
    assign unused_addr = ^data_addr_i[1:0];

    assign hit       = data_addr_i[31:5] == BASE_ADDR[31:5];
    assign offset    = data_addr_i[4:2];
    assign full_word = data_be_i == 4'hF;
    assign full      = count == CW'(PRINT_FIFO_DEPTH);
    assign count4    = 4'(count);

    // Only a PRINT push into a full FIFO is back-pressured; everything else
    // (including misses) is granted immediately.
    assign print_wr   = data_req_i & hit & data_we_i & (offset == OFF_PRINT) & data_be_i[0];
    assign data_gnt_o = data_req_i & ~(print_wr & full);
    assign push       = print_wr & data_gnt_o;
    assign pop        = print_valid_o & print_ready_i;
    assign test_wr    = data_gnt_o & hit & data_we_i & (offset == OFF_TEST) & full_word;
    assign exit_wr    = data_gnt_o & hit & data_we_i & (offset == OFF_EXIT) & full_word;

    assign print_valid_o = count != '0;
    assign print_data_o  = print_valid_o ? mem[rd_ptr] : 8'h00;

    always_comb begin
        rd_val = 32'h0;
        if (hit) begin
            case (offset)
                OFF_CYCLE:  rd_val = cycle;
                OFF_STATUS: rd_val = {27'b0, full, count4};
                default:    rd_val = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_rvalid_o  <= 1'b0;
            data_rdata_o   <= 32'h0;
            tests_passed_o <= 1'b0;
            tests_failed_o <= 1'b0;
            exit_valid_o   <= 1'b0;
            exit_value_o   <= 32'h0;
            cycle          <= 32'h0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
        end else begin
            data_rvalid_o <= data_gnt_o;
            if (data_gnt_o) data_rdata_o <= data_we_i ? 32'h0 : rd_val;
            cycle <= cycle + 32'd1;
            if (test_wr && data_wdata_i == PASS_CODE) tests_passed_o <= 1'b1;
            if (test_wr && data_wdata_i == FAIL_CODE) tests_failed_o <= 1'b1;
            exit_valid_o <= exit_wr;
            if (exit_wr) exit_value_o <= data_wdata_i;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= data_wdata_i[7:0];
    end
endmodule

// File: doc/tb_status_periph.md
Name: tb_status_periph

Overview:
- Memory-mapped virtual peripheral on the core's data bus in the verilator bench wrapper.
- It is the responder side of the bench's end-of-test handshake. Firmware stores to it, and it produces the pass, fail and exit signals that the bench top monitors to end simulation.
- It also buffers stdout characters through a small FIFO and exposes a free-running cycle counter.

Parameters:
- BASE_ADDR, 32'h2000_0000, base of the 32-byte register window (addr[31:5] match).
- PRINT_FIFO_DEPTH, 4, stdout FIFO entries; power of two, 2 to 16.
- PASS_CODE, 32'd123456789, TEST_STATUS value that signals pass.
- FAIL_CODE, 32'd1, TEST_STATUS value that signals fail.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- data_req_i  in  1  bus request.
- data_gnt_o  out  1  bus grant (combinational).
- data_we_i  in  1  1 = write.
- data_be_i  in  4  byte enables.
- data_addr_i  in  32  byte address.
- data_wdata_i  in  32  write data.
- data_rvalid_o  out  1  response valid.
- data_rdata_o  out  32  read data.
- tests_passed_o  out  1  sticky pass flag.
- tests_failed_o  out  1  sticky fail flag.
- exit_valid_o  out  1  one-cycle exit pulse.
- exit_value_o  out  32  exit code.
- print_valid_o  out  1  stdout FIFO head valid.
- print_data_o  out  8  stdout FIFO head byte.
- print_ready_i  in  1  stdout consumer ready.

Behaviour:
- Interface: one clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: all outputs 0, FIFO empty, cycle counter 0. data_gnt_o is combinational and is 0 when data_req_i = 0.
- Hit: addr[31:5] == BASE_ADDR[31:5]. Register offset is addr[4:2]. addr[1:0] is ignored.
- Register map:
  - 0x00 PRINT (W): push wdata[7:0] when be[0] = 1.
  - 0x04 TEST_STATUS (W): full word.
  - 0x08 EXIT (W): full word.
  - 0x0C CYCLE (R).
  - 0x10 STATUS (R): {27'b0, fifo_full, fifo_count[3:0]}. Bits [3:0] hold fifo_count; bits [7:5] read 0 and bit 4 is fifo_full.
  - All other offsets: reads return 0, writes are ignored.
- Grant: data_gnt_o = data_req_i & ~(hit & we & offset == PRINT & be[0] & fifo_full). Non-hit requests are granted and behave as unmapped.
- Response: data_rvalid_o asserts exactly 1 cycle after each granted request, for reads and writes alike. data_rdata_o holds the read value latched at grant, 0 for writes, and holds its value between responses. Back-to-back grants give back-to-back rvalid.
- Write side effects occur on the grant cycle edge:
  - TEST_STATUS: only when be = 4'hF. If wdata == PASS_CODE, set tests_passed_o. If wdata == FAIL_CODE, set tests_failed_o. Other values are ignored. Both flags are sticky until reset and both may end up set.
  - EXIT: only when be = 4'hF. exit_value_o <= wdata, which holds until the next EXIT write. exit_valid_o pulses high for exactly the following cycle. Consecutive EXIT writes give consecutive pulses.
  - Writes with a partial be to TEST_STATUS or EXIT are granted and acknowledged but have no effect.
- Stdout FIFO:
  - print_valid_o = ~empty and print_data_o = head byte; both are valid in the cycle of the push's rvalid.
  - A pop happens on print_valid_o & print_ready_i.
  - Simultaneous push and pop when not full: count unchanged, order preserved.
  - When full, a PRINT write is stalled by gnt = 0 and the request must be held. A pop in the same cycle does not grant that push; the grant comes in the next cycle.
  - Pointers are log2(PRINT_FIFO_DEPTH) bits and wrap modulo the depth. Count is a separate register, 0 to PRINT_FIFO_DEPTH.
- CYCLE: 32-bit counter, +1 every cycle from the first cycle after reset release, wraps 0xFFFF_FFFF -> 0. A read returns the value at grant.
- Reset mid-operation: all state clears immediately. Pending responses are dropped, with no rvalid after reset. FIFO contents are discarded.

Test Plan:
- Write 0x2000_0004 = 123456789, be F -> gnt same cycle, rvalid next cycle, tests_passed_o = 1 from then on and stays 1; tests_failed_o = 0.
- Write EXIT 0x2000_0008 = 0x0000_0005, be F, then 0x0 the next cycle -> two consecutive 1-cycle exit_valid_o pulses; exit_value_o = 5 then 0.
- Hold print_ready_i = 0 and write bytes 'A','B','C','D','E' to PRINT -> first 4 granted; STATUS not readable while stalled, so read STATUS beforehand after 4 pushes = 0x14. Fifth write: gnt = 0 until print_ready_i = 1 for one cycle, then granted the next cycle. Bytes pop in order A..E.
- Reset release, then read CYCLE at cycle N -> rdata = N-1 relative to first counted cycle. Force the counter to 0xFFFF_FFFF -> next read shows wrap to small value.
- Partial-be write (be = 4'h3) to TEST_STATUS with 123456789, and read of offset 0x18 -> both acknowledged, no flag set, rdata = 0.
- Assert rst_ni low while FIFO holds 3 bytes and a read is granted -> no rvalid follows, print_valid_o = 0, all flags 0 during and after reset.
